// File: rtl/l1a_smp_tagger.sv
// L1A event tagger: counts L1As, opens per-event sample windows, tags each ADC word one cycle late.
// Build option: define L1A_PHASE_TAG_EN to carry L1A_PHASE in bit 37 of L1A_SMP_DATA.
module l1a_smp_tagger #(
  parameter int NWIN = 8
) (
  input  logic        CLK,
  input  logic        RST_RESYNC,
  input  logic [6:0]  SAMP_MAX,
  input  logic        L1A,
  input  logic        L1A_MATCH,
  input  logic        L1A_PHASE,
  input  logic [11:0] DIN,
  input  logic        DIN_VLD,
  input  logic        DIN_FIRST,
  output logic [11:0] WDATA,
  output logic        WREN,
  output logic [37:0] L1A_SMP_DATA,
  output logic [6:0]  OVRLP_SMP_DATA,
  output logic        L1A_WRT_EN,
  output logic        DBL_L1A,
  output logic        WIN_OVF
);

  logic        phase_in;
`ifdef L1A_PHASE_TAG_EN
  assign phase_in = L1A_PHASE;
`else
  logic unused_phase;
  assign unused_phase = L1A_PHASE;
  assign phase_in     = 1'b0;
`endif

  logic [23:0] l1acnt_q, l1acnt_d;
  logic [11:0] l1amcnt_q, l1amcnt_d;
  logic        pend_q, pend_d;
  logic [37:0] latch_q, latch_d;
  logic [6:0]  rem_q [NWIN];
  logic [6:0]  rem_d [NWIN];
  logic [11:0] wdata_q, wdata_d;
  logic        wren_q, wren_d;
  logic [37:0] tag_q, tag_d;
  logic [6:0]  ovrlp_q, ovrlp_d;
  logic        wrt_en_q, wrt_en_d;
  logic        dbl_q, dbl_d;
  logic        ovf_q, ovf_d;

  logic [6:0]  samp_eff;
  logic [37:0] new_tag, eff_tag;
  logic        sample_start, found, act_any, evt_end;
  logic [3:0]  extra_cnt;

  always_comb begin
    samp_eff     = (SAMP_MAX == 7'd0) ? 7'd1 : SAMP_MAX;
    l1acnt_d     = l1acnt_q + {23'd0, L1A};
    l1amcnt_d    = l1amcnt_q + {11'd0, L1A & L1A_MATCH};
    new_tag      = {phase_in, L1A_MATCH, l1amcnt_d, l1acnt_d};
    // A same-cycle L1A supersedes whatever is already latched.
    eff_tag      = L1A ? new_tag : latch_q;
    sample_start = DIN_VLD & DIN_FIRST;

    latch_d   = eff_tag;
    pend_d    = pend_q | L1A;
    dbl_d     = dbl_q | (L1A & pend_q);
    ovf_d     = ovf_q;
    wdata_d   = DIN;
    wren_d    = DIN_VLD;
    wrt_en_d  = 1'b0;
    tag_d     = tag_q;
    ovrlp_d   = ovrlp_q;
    rem_d     = rem_q;
    found     = 1'b0;
    act_any   = 1'b0;
    evt_end   = 1'b0;
    extra_cnt = 4'd0;

    if (sample_start) begin
      if (pend_q | L1A) begin
        wrt_en_d = 1'b1;
        pend_d   = 1'b0;
        tag_d    = eff_tag;
        if (eff_tag[36]) begin
          for (int i = 0; i < NWIN; i++) begin
            if (!found && rem_q[i] == 7'd0) begin
              rem_d[i] = samp_eff;
              found    = 1'b1;
            end
          end
          if (!found) ovf_d = 1'b1;
        end
      end
      // Flags see the windows as they stand on this sample, then every live window ages by one.
      for (int i = 0; i < NWIN; i++) begin
        if (rem_d[i] != 7'd0) begin
          if (act_any && extra_cnt != 4'hF) extra_cnt = extra_cnt + 4'd1;
          act_any = 1'b1;
          if (rem_d[i] == 7'd1) evt_end = 1'b1;
          rem_d[i] = rem_d[i] - 7'd1;
        end
      end
      ovrlp_d = {evt_end, extra_cnt >= 4'd2, extra_cnt >= 4'd1, extra_cnt};
    end
  end

  always_ff @(posedge CLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      l1acnt_q  <= '0;
      l1amcnt_q <= '0;
      pend_q    <= 1'b0;
      latch_q   <= '0;
      for (int i = 0; i < NWIN; i++) rem_q[i] <= '0;
      wdata_q   <= '0;
      wren_q    <= 1'b0;
      tag_q     <= '0;
      ovrlp_q   <= '0;
      wrt_en_q  <= 1'b0;
      dbl_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      l1acnt_q  <= l1acnt_d;
      l1amcnt_q <= l1amcnt_d;
      pend_q    <= pend_d;
      latch_q   <= latch_d;
      rem_q     <= rem_d;
      wdata_q   <= wdata_d;
      wren_q    <= wren_d;
      tag_q     <= tag_d;
      ovrlp_q   <= ovrlp_d;
      wrt_en_q  <= wrt_en_d;
      dbl_q     <= dbl_d;
      ovf_q     <= ovf_d;
    end
  end

  assign WDATA          = wdata_q;
  assign WREN           = wren_q;
  assign L1A_SMP_DATA   = tag_q;
  assign OVRLP_SMP_DATA = ovrlp_q;
  assign L1A_WRT_EN     = wrt_en_q;
  assign DBL_L1A        = dbl_q;
  assign WIN_OVF        = ovf_q;

endmodule

// File: tb/tb_l1a_smp_tagger.sv
// Directed bench for l1a_smp_tagger: an NWIN=8 and an NWIN=2 instance share one stimulus stream.
module tb_l1a_smp_tagger;

`ifdef L1A_PHASE_TAG_EN
  localparam logic PH_EXP = 1'b1;
`else
  localparam logic PH_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  samp_max;
  logic        l1a, l1a_match, l1a_phase;
  logic [11:0] din;
  logic        din_vld, din_first;

  logic [11:0] wdata, wdata2;
  logic        wren, wren2;
  logic [37:0] tag, tag2;
  logic [6:0]  ovl, ovl2;
  logic        wen, wen2, dbl, dbl2, ovf, ovf2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l1a_smp_tagger #(.NWIN(8)) dut (
    .CLK(clk), .RST_RESYNC(rst), .SAMP_MAX(samp_max), .L1A(l1a), .L1A_MATCH(l1a_match),
    .L1A_PHASE(l1a_phase), .DIN(din), .DIN_VLD(din_vld), .DIN_FIRST(din_first),
    .WDATA(wdata), .WREN(wren), .L1A_SMP_DATA(tag), .OVRLP_SMP_DATA(ovl),
    .L1A_WRT_EN(wen), .DBL_L1A(dbl), .WIN_OVF(ovf)
  );

  l1a_smp_tagger #(.NWIN(2)) dut2 (
    .CLK(clk), .RST_RESYNC(rst), .SAMP_MAX(samp_max), .L1A(l1a), .L1A_MATCH(l1a_match),
    .L1A_PHASE(l1a_phase), .DIN(din), .DIN_VLD(din_vld), .DIN_FIRST(din_first),
    .WDATA(wdata2), .WREN(wren2), .L1A_SMP_DATA(tag2), .OVRLP_SMP_DATA(ovl2),
    .L1A_WRT_EN(wen2), .DBL_L1A(dbl2), .WIN_OVF(ovf2)
  );

  function automatic logic [37:0] mk_tag(input logic ph, input logic m,
                                         input logic [11:0] mc, input logic [23:0] c);
    return {ph, m, mc, c};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; l1a = 1'b0; l1a_match = 1'b0; l1a_phase = 1'b0;
    din = '0; din_vld = 1'b0; din_first = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one cycle of inputs; returns just after the capturing edge.
  task automatic send(input logic [11:0] d, input logic vld, input logic first,
                      input logic a, input logic m, input logic ph);
    @(negedge clk);
    din = d; din_vld = vld; din_first = first;
    l1a = a; l1a_match = m; l1a_phase = ph;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if ({wdata, wren, tag, ovl, wen, dbl, ovf} !== 67'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {wdata, wren, tag, ovl, wen, dbl, ovf});
    end
    n_chk++;
    if ({wdata2, wren2, tag2, ovl2, wen2, dbl2, ovf2} !== 67'd0) begin
      n_fail++; $display("FAIL reset_outputs_nwin2: got %h want 0", {wdata2, wren2, tag2, ovl2, wen2, dbl2, ovf2});
    end
  endtask

  task automatic test_single_window();
    logic [11:0] d;
    logic        exp_wen;
    logic [6:0]  exp_ov;
    do_reset();
    samp_max = 7'd4;
    send(12'hABC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_chk++;
    if (wren !== 1'b0 || wen !== 1'b0 || tag !== 38'd0) begin
      n_fail++; $display("FAIL idle_l1a: wren=%b wen=%b tag=%h want 0/0/0", wren, wen, tag);
    end
    for (int s = 1; s <= 6; s++) begin
      for (int w = 0; w < 4; w++) begin
        d = 12'(s * 16 + w);
        send(d, 1'b1, w == 0, 1'b0, 1'b0, 1'b0);
        exp_wen = (s == 1 && w == 0);
        exp_ov  = (s == 4) ? 7'h40 : 7'h00;
        n_chk++;
        if (wdata !== d || wren !== 1'b1) begin
          n_fail++; $display("FAIL single_wdata s%0d w%0d: got %h/%b want %h/1", s, w, wdata, wren, d);
        end
        n_chk++;
        if (wen !== exp_wen) begin
          n_fail++; $display("FAIL single_wrt_en s%0d w%0d: got %b want %b", s, w, wen, exp_wen);
        end
        n_chk++;
        if (ovl !== exp_ov) begin
          n_fail++; $display("FAIL single_ovrlp s%0d w%0d: got %h want %h", s, w, ovl, exp_ov);
        end
        n_chk++;
        if (tag !== mk_tag(1'b0, 1'b1, 12'd1, 24'd1)) begin
          n_fail++; $display("FAIL single_tag s%0d w%0d: got %h want %h", s, w, tag, mk_tag(1'b0, 1'b1, 12'd1, 24'd1));
        end
      end
    end
  endtask

  task automatic test_overlap();
    logic [6:0] exp_ov;
    logic       trig;
    do_reset();
    samp_max = 7'd4;
    for (int s = 1; s <= 7; s++) begin
      for (int w = 0; w < 2; w++) begin
        trig = (w == 0) && (s == 1 || s == 3);
        send(12'(s), 1'b1, w == 0, trig, trig, 1'b0);
        case (s)
          3:       exp_ov = 7'h11;
          4:       exp_ov = 7'h51;
          6:       exp_ov = 7'h40;
          default: exp_ov = 7'h00;
        endcase
        n_chk++;
        if (ovl !== exp_ov) begin
          n_fail++; $display("FAIL overlap_ovrlp s%0d w%0d: got %h want %h", s, w, ovl, exp_ov);
        end
        n_chk++;
        if (wen !== trig) begin
          n_fail++; $display("FAIL overlap_wrt_en s%0d w%0d: got %b want %b", s, w, wen, trig);
        end
      end
      if (s == 3) begin
        n_chk++;
        if (tag !== mk_tag(1'b0, 1'b1, 12'd2, 24'd2)) begin
          n_fail++; $display("FAIL overlap_tag2: got %h want %h", tag, mk_tag(1'b0, 1'b1, 12'd2, 24'd2));
        end
      end
    end
  endtask

  task automatic test_unmatched();
    logic [6:0] exp_ov;
    do_reset();
    samp_max = 7'd4;
    send(12'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(12'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (wen !== 1'b1 || tag !== mk_tag(1'b0, 1'b0, 12'd0, 24'd1) || ovl !== 7'h00) begin
      n_fail++; $display("FAIL unmatched_push: wen=%b tag=%h ov=%h want 1/%h/00", wen, tag, ovl, mk_tag(1'b0, 1'b0, 12'd0, 24'd1));
    end
    send(12'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int s = 2; s <= 6; s++) begin
      send(12'(s), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_ov = (s == 5) ? 7'h40 : 7'h00;
      n_chk++;
      if (ovl !== exp_ov) begin
        n_fail++; $display("FAIL unmatched_ovrlp s%0d: got %h want %h", s, ovl, exp_ov);
      end
      if (s == 2) begin
        n_chk++;
        if (wen !== 1'b1 || tag !== mk_tag(1'b0, 1'b1, 12'd1, 24'd2)) begin
          n_fail++; $display("FAIL matched_push: wen=%b tag=%h want 1/%h", wen, tag, mk_tag(1'b0, 1'b1, 12'd1, 24'd2));
        end
      end
    end
  endtask

  task automatic test_double_l1a();
    do_reset();
    samp_max = 7'd4;
    send(12'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_chk++;
    if (dbl !== 1'b0) begin
      n_fail++; $display("FAIL dbl_after_first: got %b want 0", dbl);
    end
    send(12'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_chk++;
    if (dbl !== 1'b1) begin
      n_fail++; $display("FAIL dbl_after_second: got %b want 1", dbl);
    end
    send(12'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (wen !== 1'b1 || tag !== mk_tag(1'b0, 1'b1, 12'd2, 24'd2)) begin
      n_fail++; $display("FAIL dbl_push: wen=%b tag=%h want 1/%h", wen, tag, mk_tag(1'b0, 1'b1, 12'd2, 24'd2));
    end
    send(12'h6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (wen !== 1'b0 || dbl !== 1'b1 || ovl !== 7'h00) begin
      n_fail++; $display("FAIL dbl_single_push: wen=%b dbl=%b ov=%h want 0/1/00", wen, dbl, ovl);
    end
  endtask

  task automatic test_win_ovf();
    logic       trig;
    logic [6:0] exp_ov2, exp_ov;
    do_reset();
    samp_max = 7'd8;
    for (int s = 1; s <= 4; s++) begin
      trig = (s <= 3);
      send(12'(s), 1'b1, 1'b1, trig, trig, 1'b0);
      exp_ov2 = (s == 1) ? 7'h00 : 7'h11;
      exp_ov  = (s == 1) ? 7'h00 : (s == 2) ? 7'h11 : 7'h32;
      n_chk++;
      if (ovl2 !== exp_ov2) begin
        n_fail++; $display("FAIL ovf_ovrlp_nwin2 s%0d: got %h want %h", s, ovl2, exp_ov2);
      end
      n_chk++;
      if (ovl !== exp_ov) begin
        n_fail++; $display("FAIL ovf_ovrlp_nwin8 s%0d: got %h want %h", s, ovl, exp_ov);
      end
      n_chk++;
      if (ovf2 !== (s >= 3) || ovf !== 1'b0) begin
        n_fail++; $display("FAIL ovf_flag s%0d: nwin2=%b nwin8=%b want %b/0", s, ovf2, ovf, s >= 3);
      end
      n_chk++;
      if (wen2 !== trig) begin
        n_fail++; $display("FAIL ovf_wrt_en s%0d: got %b want %b", s, wen2, trig);
      end
    end
  endtask

  task automatic test_same_cycle_phase();
    do_reset();
    samp_max = 7'd1;
    send(12'h11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_chk++;
    if (wen !== 1'b1 || tag !== mk_tag(PH_EXP, 1'b1, 12'd1, 24'd1)) begin
      n_fail++; $display("FAIL same_cycle_tag: wen=%b tag=%h want 1/%h", wen, tag, mk_tag(PH_EXP, 1'b1, 12'd1, 24'd1));
    end
    n_chk++;
    if (ovl !== 7'h40) begin
      n_fail++; $display("FAIL samp1_evt_end: got %h want 40", ovl);
    end
    send(12'h12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (ovl !== 7'h00 || wen !== 1'b0) begin
      n_fail++; $display("FAIL samp1_closed: ov=%h wen=%b want 00/0", ovl, wen);
    end
    samp_max = 7'd0;
    send(12'h13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_chk++;
    if (ovl !== 7'h40 || tag !== mk_tag(1'b0, 1'b1, 12'd2, 24'd2)) begin
      n_fail++; $display("FAIL samp0: ov=%h tag=%h want 40/%h", ovl, tag, mk_tag(1'b0, 1'b1, 12'd2, 24'd2));
    end
    send(12'h14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (ovl !== 7'h00) begin
      n_fail++; $display("FAIL samp0_closed: got %h want 00", ovl);
    end
  endtask

  task automatic test_reset_midwindow();
    do_reset();
    samp_max = 7'd4;
    send(12'h21, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send(12'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send(12'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(12'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({wdata, wren, tag, ovl, wen, dbl, ovf} !== 67'd0) begin
      n_fail++; $display("FAIL async_reset: got %h want 0", {wdata, wren, tag, ovl, wen, dbl, ovf});
    end
    @(negedge clk);
    rst = 1'b0;
    l1a = 1'b0; l1a_match = 1'b0;
    for (int s = 0; s < 3; s++) begin
      send(12'(s + 3), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (wen !== 1'b0 || tag !== 38'd0 || ovl !== 7'h00) begin
        n_fail++; $display("FAIL post_reset s%0d: wen=%b tag=%h ov=%h want 0/0/00", s, wen, tag, ovl);
      end
    end
  endtask

  initial begin
    rst = 1'b1; samp_max = 7'd4;
    l1a = 1'b0; l1a_match = 1'b0; l1a_phase = 1'b0;
    din = '0; din_vld = 1'b0; din_first = 1'b0;
    test_reset();
    test_single_window();
    test_overlap();
    test_unmatched();
    test_double_l1a();
    test_win_ovf();
    test_same_cycle_phase();
    test_reset_midwindow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l1a_smp_tagger.md
# l1a_smp_tagger

Upstream stage of the DAQ ring buffer. It counts L1As, opens one readout window of SAMP_MAX samples for each matched L1A, and tracks overlapping windows. It also delays the ADC word stream by one cycle, so every word reaches the ring buffer aligned with its per-sample L1A tag (L1A_SMP_DATA), overlap tag (OVRLP_SMP_DATA) and L1A write strobe.

## Interface
- NWIN, 8: number of concurrent window slots (2..16).
- CLK  in  1  system clock; all logic on rising edge.
- RST_RESYNC  in  1  reset, asynchronous, active-high.
- SAMP_MAX  in  7  samples per event window; 0 is treated as 1.
- L1A  in  1  one-cycle L1A pulse.
- L1A_MATCH  in  1  qualifies L1A; valid only when L1A=1.
- L1A_PHASE  in  1  trigger phase bit; valid only when L1A=1.
- DIN  in  12  ADC word.
- DIN_VLD  in  1  DIN valid.
- DIN_FIRST  in  1  first word of a sample; ignored unless DIN_VLD=1.
- WDATA  out  12  DIN delayed one cycle.
- WREN  out  1  DIN_VLD delayed one cycle.
- L1A_SMP_DATA  out  38  {phase, match, l1amcnt[11:0], l1acnt[23:0]}.
- OVRLP_SMP_DATA  out  7  {evt_end, multi_ovlp, ovrlap, ovrlap_cnt[3:0]}.
- L1A_WRT_EN  out  1  new-event strobe, aligned with WREN.
- DBL_L1A  out  1  sticky: a second L1A arrived before the pending one was consumed.
- WIN_OVF  out  1  sticky: matched L1A arrived while no window slot was free.

## Operation
- Counters:
  - l1acnt (24 b) increments on every L1A.
  - l1amcnt (12 b) increments on L1A & L1A_MATCH.
  - Both wrap silently.
  - The tag carries the post-increment value, so the first L1A after reset is tagged l1acnt=1.
- Pending latch:
  - An L1A loads {phase, match, l1amcnt, l1acnt} and sets pend=1.
  - If pend=1 already, the latch is overwritten with the newer L1A and DBL_L1A is set.
- Sample start means DIN_VLD & DIN_FIRST, evaluated using effective pending: pend, or an L1A arriving in the same cycle, which takes priority.
  - If pending is set, emit L1A_WRT_EN=1 on this word, clear pend, and present the latched tag.
  - If pending is matched, allocate the lowest free slot with rem = max(SAMP_MAX,1).
  - If no slot is free, set WIN_OVF and skip allocation; L1A_WRT_EN is still emitted.
  - Let A = number of slots with rem>0 after allocation:
    - ovrlap = (A>=2)
    - multi_ovlp = (A>=3)
    - ovrlap_cnt = min(A-1, 15) when A>0, else 0
    - evt_end = (any slot has rem==1)
  - After these flags are computed, every slot with rem>0 decrements.
- Non-first words (DIN_VLD & !DIN_FIRST):
  - OVRLP_SMP_DATA and L1A_SMP_DATA hold the values of the current sample.
  - L1A_WRT_EN=0.
- Unmatched L1A: pushed with match=0. The ring buffer discards it; no window is opened.
- DIN_VLD=0 cycles: WREN=0, L1A_WRT_EN=0, tags hold.

## Timing
- All outputs are registered. WDATA, WREN, the tags and L1A_WRT_EN appear exactly 1 cycle after the DIN word that produced them.
- L1A_WRT_EN is high for at most one cycle per sample start, and never without WREN.
- An L1A in cycle t is visible at the sample start in cycle t, if one exists; otherwise at the next sample start.
- A window opened at sample k covers samples k .. k+SAMP_MAX-1; evt_end is set on sample k+SAMP_MAX-1.
- Reset values:
  - all outputs 0
  - all counters 0, pend 0, all slot rem 0
  - DBL_L1A and WIN_OVF 0; both are cleared only by reset.
- If RST_RESYNC asserts mid-window, all windows are abandoned. The first word after release carries zero tags.

## Configuration
- L1A_PHASE_TAG_EN
  - Defined: the phase bit of L1A_SMP_DATA (bit 37) carries the latched L1A_PHASE.
  - Undefined: bit 37 is tied to 0 and the L1A_PHASE input is ignored.

## Test plan
- Reset, then stream samples of 4 words each with SAMP_MAX=4 and a single matched L1A:
  - one L1A_WRT_EN with l1acnt=1, l1amcnt=1
  - ovrlap_cnt=0 for 4 samples
  - evt_end on the 4th sample only
  - WDATA equals DIN delayed 1 cycle.
- Matched L1As 2 samples apart, SAMP_MAX=4:
  - samples 3-4 have ovrlap=1, ovrlap_cnt=1
  - evt_end on samples 4 and 6.
- Unmatched L1A, then a matched L1A:
  - first push has match=0, l1acnt=1, l1amcnt=0
  - second push has l1acnt=2, l1amcnt=1
  - no window opens for the first.
- Two L1As between sample starts: DBL_L1A=1; a single push carries l1acnt=2.
- NWIN=2, three matched L1As on consecutive samples, SAMP_MAX=8:
  - WIN_OVF=1
  - third L1A_WRT_EN still emitted
  - ovrlap_cnt never exceeds 1.
- L1A in the same cycle as DIN_FIRST: the tag is attached to that sample. With L1A_PHASE_TAG_EN and L1A_PHASE=1, bit 37=1.
